// File: rtl/fight_board_gen2.sv
// fight_board_gen2: two-player fighting-board core with match FSM, cooldown and draw detection.
// Optional round timer: define ROUND_TIMER_EN.
module fight_board_gen2 #(
    parameter int HLT_W        = 2,
    parameter int MAX_HLT      = 3,
    parameter int POS_W        = 2,
    parameter int ARENA_LEN    = 4,
    parameter int PUNCH_RANGE  = 1,
    parameter int KICK_RANGE   = 2,
    parameter int DMG_PUNCH    = 1,
    parameter int DMG_KICK     = 2,
    parameter int KICK_CD      = 2,
    parameter int ROUND_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    input  logic [2:0]       plr_1_act,
    input  logic [2:0]       plr_2_act,
    output logic [HLT_W-1:0] plr_1_hlt,
    output logic [HLT_W-1:0] plr_2_hlt,
    output logic [POS_W-1:0] plr_1_pos,
    output logic [POS_W-1:0] plr_2_pos,
    output logic             plr_1_lst,
    output logic             plr_2_lst,
    output logic             plr_1_cd,
    output logic             plr_2_cd,
    output logic             over
);
    typedef enum logic [1:0] {IDLE, FIGHT, DONE} state_t;
    localparam int CD_W = KICK_CD > 0 ? $clog2(KICK_CD + 1) : 1;
    localparam logic [2:0] JUMP = 3'd1, KICK = 3'd2, PUNCH = 3'd3, WARD = 3'd4, FWD = 3'd5, BACK = 3'd6;
    state_t state;
    logic [CD_W-1:0] cd_1, cd_2;
    logic [2:0] act_1, act_2;
    logic run, dead, timeout, fw_1, fw_2, blk, ln_1, ln_2;
    int gap, dmg_1, dmg_2, hn_1, hn_2, mv_1, mv_2, pn_1, pn_2;
    assign run = sw && state != DONE;
    assign plr_1_cd = cd_1 != '0;
    assign plr_2_cd = cd_2 != '0;
    assign over = plr_1_lst | plr_2_lst;
`ifdef ROUND_TIMER_EN
    localparam int RC_W = $clog2(ROUND_CYCLES + 1);
    logic [RC_W-1:0] rnd;
    assign timeout = run && int'(rnd) == ROUND_CYCLES - 1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rnd <= '0;
        else if (run) rnd <= rnd + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif
    // a player in cooldown behaves exactly as if it issued no action
    always_comb begin
        act_1 = plr_1_cd ? 3'd0 : plr_1_act;
        act_2 = plr_2_cd ? 3'd0 : plr_2_act;
        gap = int'(plr_2_pos) - int'(plr_1_pos);
        dmg_1 = (act_2 == PUNCH && gap <= PUNCH_RANGE && act_1 != WARD ? DMG_PUNCH : 0)
              + (act_2 == KICK && gap <= KICK_RANGE && act_1 != JUMP ? DMG_KICK : 0);
        dmg_2 = (act_1 == PUNCH && gap <= PUNCH_RANGE && act_2 != WARD ? DMG_PUNCH : 0)
              + (act_1 == KICK && gap <= KICK_RANGE && act_2 != JUMP ? DMG_KICK : 0);
        hn_1 = dmg_1 >= int'(plr_1_hlt) ? 0 : int'(plr_1_hlt) - dmg_1;
        hn_2 = dmg_2 >= int'(plr_2_hlt) ? 0 : int'(plr_2_hlt) - dmg_2;
        fw_1 = act_1 == FWD;
        fw_2 = act_2 == FWD;
        mv_1 = int'(plr_1_pos) + (fw_1 ? 1 : act_1 == BACK && plr_1_pos != '0 ? -1 : 0);
        mv_2 = int'(plr_2_pos) + (fw_2 ? -1 : act_2 == BACK && int'(plr_2_pos) < ARENA_LEN - 1 ? 1 : 0);
        // only forward steps can close the gap, so cancelling them always restores g >= 1
        blk = mv_2 - mv_1 < 1;
        pn_1 = blk && fw_1 ? int'(plr_1_pos) : mv_1;
        pn_2 = blk && fw_2 ? int'(plr_2_pos) : mv_2;
        dead = hn_1 == 0 || hn_2 == 0;
        ln_1 = hn_1 == 0 || (!dead && timeout && hn_1 <= hn_2);
        ln_2 = hn_2 == 0 || (!dead && timeout && hn_2 <= hn_1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            plr_1_hlt <= HLT_W'(MAX_HLT);
            plr_2_hlt <= HLT_W'(MAX_HLT);
            plr_1_pos <= '0;
            plr_2_pos <= POS_W'(ARENA_LEN - 1);
            plr_1_lst <= 1'b0;
            plr_2_lst <= 1'b0;
            cd_1      <= '0;
            cd_2      <= '0;
        end else if (run) begin
            state     <= dead || timeout ? DONE : FIGHT;
            plr_1_hlt <= HLT_W'(hn_1);
            plr_2_hlt <= HLT_W'(hn_2);
            plr_1_pos <= POS_W'(pn_1);
            plr_2_pos <= POS_W'(pn_2);
            plr_1_lst <= ln_1;
            plr_2_lst <= ln_2;
            cd_1      <= act_1 == KICK ? CD_W'(KICK_CD) : plr_1_cd ? cd_1 - 1'b1 : '0;
            cd_2      <= act_2 == KICK ? CD_W'(KICK_CD) : plr_2_cd ? cd_2 - 1'b1 : '0;
        end
    end
endmodule
